// File: rtl/wb_load_unit_pkg.sv
// rtl/wb_load_unit_pkg.sv - shared widths, load-type codes and FSM state encoding for the writeback unit
package wb_load_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    // Code 3'b111 is decoded as a plain word load.
    typedef enum logic [2:0] {
        LT_LB     = 3'b000,
        LT_LH     = 3'b001,
        LT_LWL    = 3'b010,
        LT_LW     = 3'b011,
        LT_LBU    = 3'b100,
        LT_LHU    = 3'b101,
        LT_LWR    = 3'b110,
        LT_LW_ALT = 3'b111
    } load_type_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_WRITE     = 2'd2
    } state_e;

endpackage

// File: rtl/wb_load_unit_if.sv
// rtl/wb_load_unit_if.sv - execute, memory read-data and register-file signals of the writeback unit
interface wb_load_unit_if;
    import wb_load_unit_pkg::*;

    logic                  wb_valid;
    logic                  wb_ready;
    logic                  wb_is_load;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_result;
    logic [2:0]            wb_load_type;
    logic [DATA_WIDTH-1:0] wb_rt_old;
    logic [DATA_WIDTH-1:0] Read_data;
    logic                  Read_data_Valid;
    logic                  Read_data_Ready;
    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic                  pend_valid;
    logic [ADDR_WIDTH-1:0] pend_rd;

    modport master (
        output wb_valid, wb_is_load, wb_rd, wb_result, wb_load_type, wb_rt_old,
        output Read_data, Read_data_Valid,
        input  wb_ready, Read_data_Ready, rf_wen, rf_waddr, rf_wdata, pend_valid, pend_rd
    );

    modport slave (
        input  wb_valid, wb_is_load, wb_rd, wb_result, wb_load_type, wb_rt_old,
        input  Read_data, Read_data_Valid,
        output wb_ready, Read_data_Ready, rf_wen, rf_waddr, rf_wdata, pend_valid, pend_rd
    );

endinterface

// File: rtl/wb_load_unit_load_formatter.sv
// rtl/wb_load_unit_load_formatter.sv - combinational byte/halfword extraction and LWL/LWR merge
module load_formatter
    import wb_load_unit_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] mem,
    input  logic [1:0]            off,
    input  load_type_e            load_type,
    input  logic [DATA_WIDTH-1:0] rt_old,
    output logic [DATA_WIDTH-1:0] wdata
);

    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] lwl_val;
    logic [DATA_WIDTH-1:0] lwr_val;

    always_comb begin
        byte_sel = mem[{off, 3'b000} +: 8];
        half_sel = off[1] ? mem[31:16] : mem[15:0];

        // LWL fills from the top with the low bytes of mem; LWR fills from the bottom with the high bytes.
        case (off)
            2'd0:    lwl_val = {mem[7:0],  rt_old[23:0]};
            2'd1:    lwl_val = {mem[15:0], rt_old[15:0]};
            2'd2:    lwl_val = {mem[23:0], rt_old[7:0]};
            default: lwl_val = mem;
        endcase

        case (off)
            2'd0:    lwr_val = mem;
            2'd1:    lwr_val = {rt_old[31:24], mem[31:8]};
            2'd2:    lwr_val = {rt_old[31:16], mem[31:16]};
            default: lwr_val = {rt_old[31:8],  mem[31:24]};
        endcase

        case (load_type)
            LT_LB:   wdata = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  wdata = {24'h0, byte_sel};
            LT_LH:   wdata = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  wdata = {16'h0, half_sel};
            LT_LWL:  wdata = lwl_val;
            LT_LWR:  wdata = lwr_val;
            default: wdata = mem;
        endcase
    end

endmodule

// File: rtl/wb_load_unit.sv
// rtl/wb_load_unit.sv - writeback stage: accepts ALU results or loads and pulses the register-file write port
module wb_load_unit
    import wb_load_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_load_unit_if.slave bus
);

    state_e                state;
    state_e                state_next;
    logic [ADDR_WIDTH-1:0] rd_q;
    load_type_e            type_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] rt_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] fmt_data;
    logic                  accept;
    logic                  data_take;

    load_formatter u_fmt (
        .mem       (bus.Read_data),
        .off       (off_q),
        .load_type (type_q),
        .rt_old    (rt_q),
        .wdata     (fmt_data)
    );

    always_comb begin
        accept     = bus.wb_valid && (state == ST_IDLE);
        data_take  = bus.Read_data_Valid && (state == ST_WAIT_DATA);
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = bus.wb_is_load ? ST_WAIT_DATA : ST_WRITE;
                end
            end
            ST_WAIT_DATA: begin
                if (data_take) begin
                    state_next = ST_WRITE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            rd_q    <= '0;
            type_q  <= LT_LB;
            off_q   <= '0;
            rt_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rd_q   <= bus.wb_rd;
                type_q <= load_type_e'(bus.wb_load_type);
                off_q  <= bus.wb_result[1:0];
                rt_q   <= bus.wb_rt_old;
            end
            // Write port registers only move on entry to WRITE so they hold between pulses.
            if (accept && !bus.wb_is_load) begin
                waddr_q <= bus.wb_rd;
                wdata_q <= bus.wb_result;
            end
            if (data_take) begin
                waddr_q <= rd_q;
                wdata_q <= fmt_data;
            end
        end
    end

    assign bus.wb_ready        = (state == ST_IDLE);
    assign bus.Read_data_Ready = (state == ST_WAIT_DATA);
    assign bus.rf_wen          = (state == ST_WRITE) && (rd_q != '0);
    assign bus.rf_waddr        = waddr_q;
    assign bus.rf_wdata        = wdata_q;
    assign bus.pend_valid      = (state != ST_IDLE) && (rd_q != '0);
    assign bus.pend_rd         = rd_q;

endmodule

// File: tb/tb_wb_load_unit.sv
// tb/tb_wb_load_unit.sv - randomized scoreboard bench for wb_load_unit
module tb_wb_load_unit;
    import wb_load_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_load_unit_if bus();

    wb_load_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: shifts and masks on a whole word, LWL/LWR as partial-word merges.
    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] mem,
                                             input logic [1:0] off, input logic [31:0] rt);
        logic [63:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        int          hsh;
        sh  = 8 * int'(off);
        hsh = off[1] ? 16 : 0;
        b   = 8'(mem >> sh);
        h   = 16'(mem >> hsh);
        case (t)
            3'd0: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            3'd1: return {{16{h[15]}}, h};
            3'd5: return {16'h0, h};
            3'd2: begin
                w = ({32'h0, mem} << (24 - sh)) | ({32'h0, rt} & ((64'd1 << (24 - sh)) - 64'd1));
                return w[31:0];
            end
            3'd6: begin
                w = ({32'h0, mem} >> sh) | ({32'h0, rt} & ~(64'hFFFF_FFFF >> sh));
                return w[31:0];
            end
            default: return mem;
        endcase
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.rf_wen) begin
                chk("ready_low_on_write", {31'h0, bus.wb_ready}, 32'h0);
                if (sb.size() == 0) begin
                    chk("unexpected_write", {27'h0, bus.rf_waddr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("waddr", {27'h0, bus.rf_waddr}, {27'h0, e.rd});
                    chk("wdata", bus.rf_wdata, e.data);
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.wb_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'h0, bus.wb_ready}, 32'h1);
    endtask

    task automatic do_txn(input bit is_load, input logic [4:0] rd, input logic [31:0] res,
                          input logic [2:0] t, input logic [31:0] rt, input logic [31:0] mem,
                          input int delay);
        exp_t e;
        wait_ready();
        bus.wb_valid     = 1'b1;
        bus.wb_is_load   = is_load;
        bus.wb_rd        = rd;
        bus.wb_result    = res;
        bus.wb_load_type = t;
        bus.wb_rt_old    = rt;
        if (!is_load && rd != 0) begin
            e.rd = rd; e.data = res; sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.wb_valid  = 1'b0;
        bus.wb_result = $urandom;
        bus.wb_rt_old = $urandom;
        if (is_load) begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                chk("rdr_wait", {31'h0, bus.Read_data_Ready}, 32'h1);
                chk("pend_wait", {31'h0, bus.pend_valid}, {31'h0, rd != 0});
                chk("wen_wait", {31'h0, bus.rf_wen}, 32'h0);
                if (rd != 0) chk("pend_rd", {27'h0, bus.pend_rd}, {27'h0, rd});
            end
            bus.Read_data_Valid = 1'b1;
            bus.Read_data       = mem;
            if (rd != 0) begin
                e.rd = rd; e.data = ref_load(t, mem, res[1:0], rt); sb.push_back(e);
            end
            @(posedge clk); #1;
            bus.Read_data_Valid = 1'b0;
            bus.Read_data       = $urandom;
        end
        @(negedge clk);
        chk("wen_pulse", {31'h0, bus.rf_wen}, {31'h0, rd != 0});
        chk("ready_in_write", {31'h0, bus.wb_ready}, 32'h0);
        chk("pend_in_write", {31'h0, bus.pend_valid}, {31'h0, rd != 0});
        @(negedge clk);
        chk("ready_after", {31'h0, bus.wb_ready}, 32'h1);
        chk("wen_after", {31'h0, bus.rf_wen}, 32'h0);
        chk("pend_after", {31'h0, bus.pend_valid}, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'h0, bus.wb_ready}, 32'h1);
        chk({tag, "_rdr"}, {31'h0, bus.Read_data_Ready}, 32'h0);
        chk({tag, "_wen"}, {31'h0, bus.rf_wen}, 32'h0);
        chk({tag, "_pend"}, {31'h0, bus.pend_valid}, 32'h0);
        chk({tag, "_waddr"}, {27'h0, bus.rf_waddr}, 32'h0);
        chk({tag, "_wdata"}, bus.rf_wdata, 32'h0);
        chk({tag, "_pend_rd"}, {27'h0, bus.pend_rd}, 32'h0);
    endtask

    task automatic idle_valid_pulse();
        wait_ready();
        bus.Read_data_Valid = 1'b1;
        bus.Read_data       = $urandom;
        @(negedge clk);
        bus.Read_data_Valid = 1'b0;
        chk("idle_pulse_ready", {31'h0, bus.wb_ready}, 32'h1);
        chk("idle_pulse_wen", {31'h0, bus.rf_wen}, 32'h0);
        chk("idle_pulse_rdr", {31'h0, bus.Read_data_Ready}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                 = 1'b1;
        bus.wb_valid        = 1'b0;
        bus.wb_is_load      = 1'b0;
        bus.wb_rd           = '0;
        bus.wb_result       = '0;
        bus.wb_load_type    = '0;
        bus.wb_rt_old       = '0;
        bus.Read_data       = '0;
        bus.Read_data_Valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 5'd5, 32'h1234_5678, 3'd0, 32'h0, 32'h0, 0);
        do_txn(1'b1, 5'd3, 32'h0000_1001, 3'd0, 32'h0, 32'h1122_8344, 1);
        do_txn(1'b1, 5'd4, 32'h0000_1001, 3'd4, 32'h0, 32'h1122_8344, 0);
        do_txn(1'b1, 5'd6, 32'h0000_2002, 3'd5, 32'h0, 32'h80FF_0000, 2);
        do_txn(1'b1, 5'd7, 32'h0000_0011, 3'd2, 32'hAABB_CCDD, 32'h1122_3344, 0);
        do_txn(1'b1, 5'd8, 32'h0000_0011, 3'd6, 32'hAABB_CCDD, 32'h1122_3344, 1);
        do_txn(1'b1, 5'd9, 32'h0000_0013, 3'd2, 32'hAABB_CCDD, 32'h1122_3344, 0);
        do_txn(1'b1, 5'd10, 32'h0000_0040, 3'd3, 32'h0, 32'hCAFE_F00D, 5);
        idle_valid_pulse();
        do_txn(1'b1, 5'd0, 32'h0000_0002, 3'd1, 32'h0, 32'h8000_1234, 3);

        // Reset while waiting for read data abandons the load.
        wait_ready();
        bus.wb_valid   = 1'b1;
        bus.wb_is_load = 1'b1;
        bus.wb_rd      = 5'd12;
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        chk("rst_case_rdr", {31'h0, bus.Read_data_Ready}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.Read_data_Valid = 1'b1;
        bus.Read_data       = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.Read_data_Valid = 1'b0;
        @(negedge clk);
        check_reset_values("rst_wait");

        for (int n = 0; n < 150; n++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            do_txn(1'($urandom_range(0, 1)), rd, $urandom, 3'($urandom_range(0, 7)),
                   $urandom, $urandom, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) idle_valid_pulse();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
